// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one step per clock) feeding a 4-digit display.
// Define BIN2BCD_LZB_EN to blank leading zero digits with 4'hF.
module bin2bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);
    localparam logic [3:0] BLANK     = 4'hF;

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_step;
    logic   w_finish;

    // {scratch[15:0], shift[BIN_W-1:0]} kept as one register so a single shift moves both
    logic [BIN_W+15:0] r_dd;
    logic [3:0]        r_cnt;
    logic              r_ovf_pend;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
    logic [3:0]        r_digit3;
    logic [3:0]        r_digit2;
    logic [3:0]        r_digit1;
    logic [3:0]        r_digit0;

    logic [15:0]       w_adj;
    logic              w_over;
    logic [3:0]        w_d3;
    logic [3:0]        w_d2;
    logic [3:0]        w_d1;
    logic [3:0]        w_d0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_dd[BIN_W + 4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_dd[BIN_W + 4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_dd[BIN_W + 4*i +: 4];
            end
        end
    end

    assign w_over = ({{(32-BIN_W){1'b0}}, bin} > 32'd9999);

    // Final digit formatting: overflow blanks everything, optional leading-zero blanking otherwise
    always_comb begin
        w_d3 = r_dd[BIN_W+12 +: 4];
        w_d2 = r_dd[BIN_W+8  +: 4];
        w_d1 = r_dd[BIN_W+4  +: 4];
        w_d0 = r_dd[BIN_W    +: 4];
`ifdef BIN2BCD_LZB_EN
        if (w_d3 == 4'd0) begin
            w_d3 = BLANK;
            if (w_d2 == 4'd0) begin
                w_d2 = BLANK;
                if (w_d1 == 4'd0) begin
                    w_d1 = BLANK;
                end
            end
        end
`endif
        if (r_ovf_pend) begin
            w_d3 = BLANK;
            w_d2 = BLANK;
            w_d1 = BLANK;
            w_d0 = BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dd       <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_digit3   <= 4'h0;
            r_digit2   <= 4'h0;
            r_digit1   <= 4'h0;
            r_digit0   <= 4'h0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_next != S_IDLE);
            if (w_load) begin
                r_dd       <= {16'h0000, bin};
                r_cnt      <= 4'd0;
                r_ovf_pend <= w_over;
            end else if (w_step) begin
                r_dd  <= {w_adj, r_dd[BIN_W-1:0]} << 1;
                r_cnt <= r_cnt + 4'd1;
            end
            // Visible outputs change only here, so the display never sees partial results
            if (w_finish) begin
                r_digit3 <= w_d3;
                r_digit2 <= w_d2;
                r_digit1 <= w_d1;
                r_digit0 <= w_d0;
                r_ovf    <= r_ovf_pend;
                r_done   <= 1'b1;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ovf    = r_ovf;
    assign digit3 = r_digit3;
    assign digit2 = r_digit2;
    assign digit1 = r_digit1;
    assign digit0 = r_digit0;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an arithmetic reference model pushes expected results,
// a negedge monitor compares busy/done/digits every cycle.
module tb_bin2bcd_seq;

    localparam int BIN_W   = 14;
    localparam int LATENCY = BIN_W + 1;

    typedef struct {
        logic [16:0] res;
        int          due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       digit3;
    logic [3:0]       digit2;
    logic [3:0]       digit1;
    logic [3:0]       digit0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          free_edge = 0;
    int          busy_end = 0;
    logic [16:0] exp_last = '0;
    exp_t        exp_q[$];

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .digit3 (digit3),
        .digit2 (digit2),
        .digit1 (digit1),
        .digit0 (digit0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result {ovf, d3, d2, d1, d0} from plain decimal arithmetic
    function automatic logic [16:0] model(input int v);
        logic [3:0] d3, d2, d1, d0;
        if (v > 9999) return {1'b1, 16'hFFFF};
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
`ifdef BIN2BCD_LZB_EN
        if (v < 1000) d3 = 4'hF;
        if (v < 100)  d2 = 4'hF;
        if (v < 10)   d1 = 4'hF;
`endif
        return {1'b0, d3, d2, d1, d0};
    endfunction

    // Acceptance model: a request is taken at an edge only once the previous one has finished
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (!rst) begin
            free_edge = 0;
            busy_end  = 0;
        end else if (start && cyc >= free_edge) begin
            e.res = model(int'(bin));
            e.due = cyc + LATENCY;
            exp_q.push_back(e);
            busy_end  = cyc + LATENCY;
            free_edge = cyc + LATENCY + 1;
        end
    end

    always @(negedge clk) begin
        exp_t h;
        if (!rst) begin
            exp_q.delete();
            exp_last = '0;
            check("busy_rst", 32'(busy), 32'd0);
            check("done_rst", 32'(done), 32'd0);
        end else begin
            check("busy", 32'(busy), 32'(cyc < busy_end));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                h = exp_q.pop_front();
                exp_last = h.res;
                check("done", 32'(done), 32'd1);
            end else begin
                check("done_stray", 32'(done), 32'd0);
            end
        end
        check("digits", 32'({ovf, digit3, digit2, digit1, digit0}), 32'(exp_last));
    end

    task automatic pulse(input int v);
        @(posedge clk); #2;
        start = 1'b1;
        bin   = BIN_W'(v);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int vals[4];
        bit seen;
        vals = '{0, 9999, 10000, 16383};

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        pulse(1234);
        drain();

        foreach (vals[i]) begin
            pulse(vals[i]);
            drain();
        end

        // Request during a conversion must be dropped
        pulse(5678);
        repeat (3) @(posedge clk);
        pulse(1111);
        drain();

        // Start held high; value changes during the done cycle
        @(posedge clk); #2;
        start = 1'b1;
        bin   = BIN_W'(7);
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #2;
            if (done) seen = 1'b1;
        end
        if (!seen) check("held_done_timeout", 32'd0, 32'd1);
        bin = BIN_W'(42);
        repeat (40) @(posedge clk);
        #2 start = 1'b0;
        drain();

        // Reset in the middle of a conversion
        pulse(1234);
        drain();
        pulse(8765);
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) @(posedge clk);

        // Random traffic, biased toward range boundaries
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0:       bin = BIN_W'($urandom_range(9990, 10010));
                1:       bin = BIN_W'($urandom_range(0, 12));
                default: bin = BIN_W'($urandom_range(0, 16383));
            endcase
        end
        #0 start = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
